// File: rtl/jtag_dr_ctrl.sv
// JTAG data-register controller: IR decode, DR capture/shift/update, debug bus requests.
// Define JTAG_DR_TIMEOUT_EN to abandon accesses after TIMEOUT_CYC TCK cycles.
module jtag_dr_ctrl #(
  parameter logic [31:0] IDCODE      = 32'h1000_0001,
  parameter int          ADDR_W      = 7,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              tck_i,
  input  logic              trst_ni,
  input  logic [4:0]        ir_i,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic              td_i,
  output logic              td_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [31:0]       req_wdata_o,
  input  logic              rsp_valid_i,
  input  logic              rsp_err_i,
  input  logic [31:0]       rsp_rdata_i
);

  localparam int SW = ADDR_W + 34;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SW-1:0]     r_shift;
  logic [SW-1:0]     w_shift_nxt;
  logic [SW-1:0]     w_sr1;
  logic [SW-1:0]     w_cap_val;
  logic [1:0]        r_sticky;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;

  logic              w_sel_id;
  logic              w_sel_st;
  logic              w_sel_acc;
  logic              w_sel_byp;
  logic [6:0]        w_len;
  logic              w_busy;
  logic              w_upd;
  logic              w_acc_upd;
  logic              w_start;
  logic              w_done;
  logic              w_timeout;
  logic [1:0]        w_op;
  logic [1:0]        w_acc_op;
  logic [31:0]       w_acc_data;
  logic [ADDR_W-1:0] w_acc_addr;

  assign w_sel_id  = (ir_i == 5'h01);
  assign w_sel_st  = (ir_i == 5'h10);
  assign w_sel_acc = (ir_i == 5'h11);
  assign w_sel_byp = ~(w_sel_id | w_sel_st | w_sel_acc);

  assign w_len = w_sel_acc ? 7'(SW) :
                 (w_sel_id | w_sel_st) ? 7'd32 : 7'd1;

  assign w_busy     = (r_state != S_IDLE);
  assign w_op       = w_busy ? 2'd3 : r_sticky;
  assign w_acc_op   = r_shift[1:0];
  assign w_acc_data = r_shift[33:2];
  assign w_acc_addr = r_shift[ADDR_W+33:34];

  assign w_upd     = update_dr_i & ~capture_dr_i & ~shift_dr_i;
  assign w_acc_upd = w_upd & w_sel_acc;
  assign w_start   = w_acc_upd & ~w_busy & (r_sticky == 2'd0) &
                     ((w_acc_op == 2'd1) | (w_acc_op == 2'd2));

  always_comb begin
    w_cap_val = '0;
    unique case (1'b1)
      w_sel_id: w_cap_val[31:0] = IDCODE;
      w_sel_st: begin
        w_cap_val[3:0]   = 4'h1;
        w_cap_val[9:4]   = 6'(ADDR_W);
        w_cap_val[11:10] = r_sticky;
      end
      w_sel_acc: w_cap_val = {r_last_addr, r_rdata, w_op};
      w_sel_byp: w_cap_val = '0;
      default:   w_cap_val = '0;
    endcase
  end

  // td_i lands at bit len-1; everything above the selected length clears
  assign w_sr1 = {1'b0, r_shift[SW-1:1]};

  always_comb begin
    w_shift_nxt = '0;
    for (int i = 0; i < SW; i++) begin
      if (7'(i) == w_len - 7'd1) begin
        w_shift_nxt[i] = td_i;
      end else if (7'(i) < w_len - 7'd1) begin
        w_shift_nxt[i] = w_sr1[i];
      end
    end
  end

`ifdef JTAG_DR_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] r_cnt;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign w_timeout = w_busy & (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (req_ready_i) begin
          if (rsp_valid_i) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rsp_valid_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_shift     <= '0;
      r_sticky    <= 2'd0;
      r_rdata     <= '0;
      r_last_addr <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
    end else begin
      if (capture_dr_i) begin
        r_shift <= w_cap_val;
      end else if (shift_dr_i) begin
        r_shift <= w_shift_nxt;
      end
      if (w_start) begin
        r_addr      <= w_acc_addr;
        r_wdata     <= w_acc_data;
        r_we        <= w_acc_op[1];
        r_last_addr <= w_acc_addr;
      end
      if (w_done && !r_we) begin
        r_rdata <= rsp_rdata_i;
      end
      // later assignments win: bus errors outrank a same-cycle clear
      if (w_upd && w_sel_st && r_shift[16]) begin
        r_sticky <= 2'd0;
      end
      if (w_acc_upd && w_busy) begin
        r_sticky <= 2'd3;
      end
      if ((w_done && rsp_err_i) || w_timeout) begin
        r_sticky <= 2'd2;
      end
    end
  end

  assign td_o        = r_shift[0];
  assign req_valid_o = (r_state == S_REQ);
  assign req_we_o    = r_we;
  assign req_addr_o  = r_addr;
  assign req_wdata_o = r_wdata;

endmodule

// File: tb/tb_jtag_dr_ctrl.sv
// Bench for jtag_dr_ctrl: directed scans, behavioural model checked every cycle.
// Define JTAG_DR_TIMEOUT_EN to also exercise the access timeout.
module tb_jtag_dr_ctrl;

  localparam int          AW = 7;
  localparam int          TO = 16;
  localparam logic [31:0] ID = 32'h1000_0001;

  logic          tck_i = 1'b0;
  logic          trst_ni = 1'b1;
  logic [4:0]    ir_i = '0;
  logic          capture_dr_i = 1'b0;
  logic          shift_dr_i = 1'b0;
  logic          update_dr_i = 1'b0;
  logic          td_i = 1'b0;
  logic          td_o;
  logic          req_valid_o;
  logic          req_ready_i = 1'b0;
  logic          req_we_o;
  logic [AW-1:0] req_addr_o;
  logic [31:0]   req_wdata_o;
  logic          rsp_valid_i = 1'b0;
  logic          rsp_err_i = 1'b0;
  logic [31:0]   rsp_rdata_i = '0;

  jtag_dr_ctrl #(
    .IDCODE     (ID),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .tck_i       (tck_i),
    .trst_ni     (trst_ni),
    .ir_i        (ir_i),
    .capture_dr_i(capture_dr_i),
    .shift_dr_i  (shift_dr_i),
    .update_dr_i (update_dr_i),
    .td_i        (td_i),
    .td_o        (td_o),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_we_o    (req_we_o),
    .req_addr_o  (req_addr_o),
    .req_wdata_o (req_wdata_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_err_i   (rsp_err_i),
    .rsp_rdata_i (rsp_rdata_i)
  );

  always #5 tck_i = ~tck_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [65:0] act,
                     input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [65:0]   m_sr = '0;
  int            m_phase = 0;
  logic [1:0]    m_sticky = '0;
  logic [31:0]   m_rdata = '0;
  logic [AW-1:0] m_last = '0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = '0;
  logic          m_we = 1'b0;
  int            m_cnt = 0;
  int            L;
  int            ph;
  int            ph_n;
  logic [65:0]   msk;
  logic [1:0]    op;
  logic          done;

  function automatic int dr_len(input logic [4:0] ir);
    case (ir)
      5'h01, 5'h10: return 32;
      5'h11:        return AW + 34;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [65:0] cap_value(input logic [4:0] ir,
                                            input bit busy);
    case (ir)
      5'h01: return 66'(ID);
      5'h10: return 66'd1 + (66'(AW) << 4) + (66'(m_sticky) << 10);
      5'h11: return (66'(m_last) << 34) | (66'(m_rdata) << 2) |
                    (busy ? 66'd3 : 66'(m_sticky));
      default: return '0;
    endcase
  endfunction

  always @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      m_sr = '0; m_phase = 0; m_sticky = '0; m_rdata = '0;
      m_last = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_cnt = 0;
    end else begin
      L = dr_len(ir_i);
      ph = m_phase;
      ph_n = m_phase;
      if (capture_dr_i) begin
        m_sr = cap_value(ir_i, ph != 0);
      end else if (shift_dr_i) begin
        msk = (66'd1 << L) - 66'd1;
        m_sr = ((m_sr & msk) >> 1) | ({65'd0, td_i} << (L - 1));
      end else if (update_dr_i) begin
        if (ir_i == 5'h10 && m_sr[16]) m_sticky = 2'd0;
        if (ir_i == 5'h11) begin
          op = m_sr[1:0];
          if (ph != 0) begin
            m_sticky = 2'd3;
          end else if (m_sticky == 0 && (op == 1 || op == 2)) begin
            m_addr = m_sr[AW+33:34];
            m_wdata = m_sr[33:2];
            m_we = (op == 2);
            m_last = m_addr;
            m_cnt = 0;
            ph_n = 1;
          end
        end
      end
      done = 1'b0;
      if (ph == 1 && req_ready_i) begin
        if (rsp_valid_i) done = 1'b1;
        else ph_n = 2;
      end
      if (ph == 2 && rsp_valid_i) done = 1'b1;
      if (done) begin
        ph_n = 0;
        if (!m_we) m_rdata = rsp_rdata_i;
        if (rsp_err_i) m_sticky = 2'd2;
      end
`ifdef JTAG_DR_TIMEOUT_EN
      if (ph != 0) begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_sticky = 2'd2;
          ph_n = 0;
        end
      end
`endif
      m_phase = ph_n;
    end
  end

  always @(negedge tck_i) begin
    chk("td_o", 66'(td_o), 66'(m_sr[0]));
    chk("req_valid", 66'(req_valid_o), 66'(m_phase == 1));
    if (m_phase == 1) begin
      chk("req_we", 66'(req_we_o), 66'(m_we));
      chk("req_addr", 66'(req_addr_o), 66'(m_addr));
      chk("req_wdata", 66'(req_wdata_o), 66'(m_wdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge tck_i);
    #2;
  endtask

  task automatic scan(input logic [4:0] ir, input int len,
                      input logic [65:0] din, input bit upd,
                      output logic [65:0] dout);
    dout = '0;
    ir_i = ir;
    capture_dr_i = 1'b1;
    step();
    capture_dr_i = 1'b0;
    shift_dr_i = 1'b1;
    for (int k = 0; k < len; k++) begin
      td_i = din[k];
      dout[k] = td_o;
      step();
    end
    shift_dr_i = 1'b0;
    td_i = 1'b0;
    if (upd) begin
      update_dr_i = 1'b1;
      step();
      update_dr_i = 1'b0;
    end
  endtask

  function automatic logic [65:0] acc(input logic [AW-1:0] a,
                                      input logic [31:0] d,
                                      input logic [1:0] o);
    return {25'd0, a, d, o};
  endfunction

  localparam int AL = AW + 34;
  logic [65:0] d;
  int vcnt;

  initial begin
    #1 trst_ni = 1'b0;
    step();
    step();
    chk("rst_td_o", 66'(td_o), 66'd0);
    chk("rst_valid", 66'(req_valid_o), 66'd0);
    chk("rst_addr", 66'(req_addr_o), 66'd0);
    trst_ni = 1'b1;
    step();

    scan(5'h01, 32, '0, 1'b0, d);
    chk("idcode", 66'(d[31:0]), 66'(32'h1000_0001));

    scan(5'h1F, 9, 66'h0A5, 1'b0, d);
    chk("bypass", 66'(d[8:0]), 66'h14A);

    // write, ready after three valid cycles
    scan(5'h11, AL, acc(7'h10, 32'hDEADBEEF, 2'd2), 1'b1, d);
    chk("wr_valid", 66'(req_valid_o), 66'd1);
    chk("wr_we", 66'(req_we_o), 66'd1);
    chk("wr_addr", 66'(req_addr_o), 66'h10);
    chk("wr_data", 66'(req_wdata_o), 66'hDEADBEEF);
    step();
    step();
    chk("wr_hold", 66'(req_valid_o), 66'd1);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    chk("wr_drop", 66'(req_valid_o), 66'd0);
    rsp_valid_i = 1'b1;
    step();
    rsp_valid_i = 1'b0;
    scan(5'h11, AL, '0, 1'b1, d);
    chk("wr_cap", d, acc(7'h10, 32'h0, 2'd0));

    // read with response in the accepting cycle
    scan(5'h11, AL, acc(7'h05, 32'h0, 2'd1), 1'b1, d);
    chk("rd_we", 66'(req_we_o), 66'd0);
    req_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'h1234_5678;
    step();
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_rdata_i = '0;
    chk("rd_idle", 66'(req_valid_o), 66'd0);
    scan(5'h11, AL, '0, 1'b1, d);
    chk("rd_cap", d, acc(7'h05, 32'h1234_5678, 2'd0));

    // update while busy raises sticky 3
    scan(5'h11, AL, acc(7'h03, 32'h0000_CAFE, 2'd2), 1'b1, d);
    scan(5'h11, AL, acc(7'h04, 32'h0, 2'd1), 1'b1, d);
    chk("busy_op", 66'(d[1:0]), 66'd3);
    chk("busy_addr", 66'(req_addr_o), 66'h03);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    step();
    rsp_valid_i = 1'b0;
    scan(5'h10, 32, '0, 1'b1, d);
    chk("st_sticky3", 66'(d[31:0]), 66'h0C71);
    scan(5'h11, AL, acc(7'h06, 32'h0, 2'd1), 1'b1, d);
    chk("sticky_op", 66'(d[1:0]), 66'd3);
    chk("ignored", 66'(req_valid_o), 66'd0);
    step();
    chk("ignored2", 66'(req_valid_o), 66'd0);
    scan(5'h10, 32, 66'h1_0000, 1'b1, d);
    scan(5'h10, 32, '0, 1'b0, d);
    chk("st_clear", 66'(d[31:0]), 66'h0071);
    scan(5'h11, AL, '0, 1'b1, d);
    chk("last_kept", d, acc(7'h03, 32'h1234_5678, 2'd0));

    // error response
    scan(5'h11, AL, acc(7'h07, 32'h0, 2'd1), 1'b1, d);
    req_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    rsp_err_i = 1'b1;
    rsp_rdata_i = 32'hA5A5_0000;
    step();
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_err_i = 1'b0;
    rsp_rdata_i = '0;
    scan(5'h10, 32, '0, 1'b1, d);
    chk("st_err", 66'(d[31:0]), 66'h0871);
    scan(5'h11, AL, '0, 1'b1, d);
    chk("err_cap", d, acc(7'h07, 32'hA5A5_0000, 2'd2));
    scan(5'h10, 32, 66'h1_0000, 1'b1, d);

    // async reset during an outstanding request
    scan(5'h11, AL, acc(7'h11, 32'h5555_AAAA, 2'd2), 1'b1, d);
    chk("pre_rst", 66'(req_valid_o), 66'd1);
    #1 trst_ni = 1'b0;
    #1;
    chk("rst_drop", 66'(req_valid_o), 66'd0);
    chk("rst_we", 66'(req_we_o), 66'd0);
    step();
    trst_ni = 1'b1;
    step();
    scan(5'h11, AL, '0, 1'b0, d);
    chk("rst_cap", d, '0);

`ifdef JTAG_DR_TIMEOUT_EN
    scan(5'h11, AL, acc(7'h22, 32'h1, 2'd2), 1'b1, d);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (req_valid_o) vcnt++;
      step();
    end
    chk("to_cycles", 66'(vcnt), 66'(TO));
    scan(5'h10, 32, '0, 1'b0, d);
    chk("to_sticky", 66'(d[11:10]), 66'd2);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
